reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index dumped.
REQ-002 Parameter LAST_REG, default 31: last register index dumped; the block SHALL require FIRST_REG <= LAST_REG <= 31.
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  request one full dump; sampled only in IDLE.
REQ-006 Port abort  input  1  terminate an in-progress dump.
REQ-007 Port rf_addr  output  5  register index driven to a register-file asynchronous read port.
REQ-008 Port rf_data  input  32  combinational read data for rf_addr.
REQ-009 Port out_valid  output  1  out_index/out_data hold a valid word.
REQ-010 Port out_ready  input  1  consumer accepts the word.
REQ-011 Port out_index  output  5  register index of the presented word.
REQ-012 Port out_data  output  32  captured register value.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port done  output  1  one-cycle pulse at the end of a dump.
REQ-015 Port checksum  output  32  XOR of all words accepted in the current or last dump.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, READ, SEND and FINISH.
REQ-017 IDLE: start=1 SHALL load idx=FIRST_REG, clear checksum to 0, and go to READ on the next edge.
REQ-018 READ: rf_addr=idx; at the edge, out_data<=rf_data and out_index<=idx, then go to SEND; this gives one cycle from READ entry to valid.
REQ-019 rf_addr SHALL equal idx in every state; its value is irrelevant outside READ.
REQ-020 SEND: out_valid=1; out_index and out_data SHALL stay stable until the handshake (out_valid && out_ready at a rising edge).
REQ-021 On the handshake, checksum<=checksum^out_data; if idx==LAST_REG go to FINISH, otherwise idx<=idx+1 and go to READ.
REQ-022 idx arithmetic SHALL be 5-bit with no wrap past LAST_REG; 31 is the maximum and SHALL never increment.
REQ-023 FINISH: done=1 for exactly one cycle, then go to IDLE.
REQ-024 checksum SHALL hold its value in IDLE until the next accepted start.
REQ-025 start asserted in any state other than IDLE SHALL be ignored; no queuing.
REQ-026 abort=1 in READ or SEND SHALL go to IDLE on the next edge, drop out_valid, and raise no done; abort has priority over a simultaneous handshake, and that word SHALL NOT enter the checksum.
REQ-027 abort in IDLE or FINISH SHALL have no effect.
REQ-028 In IDLE, start and abort high together: start SHALL win.
REQ-029 out_valid and done SHALL never be high in the same cycle.
REQ-030 A dump with FIRST_REG=LAST_REG SHALL emit exactly one word.

Reset
REQ-031 reset=1 SHALL immediately (asynchronously) force state=IDLE, idx=FIRST_REG, out_data=0, out_index=0, checksum=0.
REQ-032 While reset is high: out_valid=0, busy=0, done=0, rf_addr=FIRST_REG.
REQ-033 Reset mid-dump SHALL discard the dump; the first edge after reset deassertion SHALL sample start in IDLE.

Structure
REQ-034 The state encoding (IDLE/READ/SEND/FINISH) and the register-index width constant (5) SHALL live in the shared CPU package.
REQ-035 The block SHALL be one module, with the index counter optionally split into a sub-module named dump_index_counter (load, increment, last flag).
REQ-036 The block SHALL only read the register file; it SHALL drive no write-enable or write data.

Verification
REQ-037 Registers hold value i*3, out_ready=1, start pulse -> 32 words, indices 0..31, data i*3, one word every 2 cycles, done 64 cycles after the first READ, checksum equals XOR of i*3.
REQ-038 out_ready held low for 5 cycles in SEND at index 4 -> out_valid stays high, index 4 and data stable, no extra checksum update.
REQ-039 abort asserted at index 10 in SEND with out_ready=1 -> IDLE next edge, no done, checksum equals XOR of indices 0..9 only.
REQ-040 reset asserted mid-cycle during SEND -> out_valid=0 and busy=0 without waiting for a clock edge; start after release begins a fresh dump at index 0.
REQ-041 start pulsed again while busy -> ignored, exactly 32 words and one done.
REQ-042 FIRST_REG=LAST_REG=2, x2=0x2ffc -> one word (index 2, 0x2ffc), checksum 0x2ffc, done.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// reg_dump_reader_pkg
// Shared definitions for the register-dump reader: the register-index width,
// the data width and the reader FSM state encoding.
package reg_dump_reader_pkg;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;

    // Highest index that fits in IDX_W bits; the counter must never step past it.
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        FINISH
    } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if
// Groups the register-file read port and the output word stream.
//   rf_addr   : register index driven to the register file's async read port
//   rf_data   : combinational read data for rf_addr
//   out_valid : out_index/out_data hold a valid word
//   out_ready : consumer accepts the word
//   out_index : register index of the presented word
//   out_data  : captured register value
// master = the reader, slave = register file plus consumer.
interface reg_dump_reader_if;
    import reg_dump_reader_pkg::*;

    idx_t  rf_addr;
    word_t rf_data;
    logic  out_valid;
    logic  out_ready;
    idx_t  out_index;
    word_t out_data;

    modport master (
        output rf_addr,
        input  rf_data,
        output out_valid,
        input  out_ready,
        output out_index,
        output out_data
    );

    modport slave (
        input  rf_addr,
        output rf_data,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_data
    );

endinterface

// File: rtl/reg_dump_reader_counter.sv
// dump_index_counter
// Register index counter for the dump reader.
//   clk, reset : clock, asynchronous active-high reset (index -> FIRST_REG)
//   load       : restart the count at FIRST_REG
//   inc        : step to the next index; ignored at LAST_REG or at the 5-bit maximum
//   idx        : current register index
//   last       : idx equals LAST_REG
module dump_index_counter
    import reg_dump_reader_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output idx_t idx,
    output logic last
);

    localparam idx_t FIRST_IDX = idx_t'(FIRST_REG);
    localparam idx_t LAST_IDX  = idx_t'(LAST_REG);

    assign last = (idx == LAST_IDX);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= FIRST_IDX;
        end else if (load) begin
            idx <= FIRST_IDX;
        end else if (inc && !last && (idx != IDX_MAX)) begin
            idx <= idx + idx_t'(1);
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// Walks register indices FIRST_REG..LAST_REG (FIRST_REG <= LAST_REG <= 31),
// reading each one through an asynchronous register-file read port and
// presenting it as a valid/ready word stream. The XOR of every accepted word
// is kept in checksum. Read-only: it never writes the register file.
//   clk, reset : clock, asynchronous active-high reset
//   start      : request one full dump (sampled only in IDLE)
//   abort      : drop an in-progress dump (READ/SEND only), no done pulse
//   bus        : register-file read port and output word stream (master side)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when a dump completes
//   checksum   : XOR of words accepted in the current or last dump
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    reg_dump_reader_if.master   bus,
    output logic                busy,
    output logic                done,
    output word_t               checksum
);

    state_t state;
    state_t state_nxt;

    logic  load;
    logic  inc;
    logic  capture;
    logic  accept;
    idx_t  idx;
    logic  last;
    idx_t  out_index_q;
    word_t out_data_q;

    dump_index_counter #(
        .FIRST_REG (FIRST_REG),
        .LAST_REG  (LAST_REG)
    ) u_index (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .inc   (inc),
        .idx   (idx),
        .last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        inc       = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                // start beats abort here; abort has no meaning while idle.
                if (start) begin
                    load      = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // abort outranks a coincident handshake: that word is dropped.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bus.out_ready) begin
                    accept = 1'b1;
                    if (last) begin
                        state_nxt = FINISH;
                    end else begin
                        inc       = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: the word and checksum registers are reset explicitly because their
    // values are architecturally visible right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_index_q <= '0;
            out_data_q  <= '0;
            checksum    <= '0;
        end else begin
            if (capture) begin
                out_index_q <= idx;
                out_data_q  <= bus.rf_data;
            end
            if (load) begin
                checksum <= '0;
            end else if (accept) begin
                checksum <= checksum ^ out_data_q;
            end
        end
    end

    // Status decodes straight from state, so reset clears them without a clock.
    assign bus.rf_addr   = idx;
    assign bus.out_index = out_index_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state == SEND);
    assign done          = (state == FINISH);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader
// Scoreboard bench: each issued dump pushes its expected words and final
// checksum into queues; a monitor on the falling edge pops and compares on
// every handshake and every done pulse. Inputs change 1 ns after the rising edge.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  start, abort, busy, done;
    word_t checksum;
    logic  start2, abort2, busy2, done2;
    word_t checksum2;

    always #5 clk = ~clk;

    word_t regs [32];

    reg_dump_reader_if bus ();
    reg_dump_reader_if bus2 ();

    assign bus.rf_data  = regs[bus.rf_addr];
    assign bus2.rf_data = regs[bus2.rf_addr];

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    reg_dump_reader #(.FIRST_REG(2), .LAST_REG(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .abort    (abort2),
        .bus      (bus2.master),
        .busy     (busy2),
        .done     (done2),
        .checksum (checksum2)
    );

    typedef struct {
        int    index;
        word_t data;
    } exp_word_t;

    exp_word_t exp_q [$];
    word_t     chk_q [$];
    int        tests    = 0;
    int        fails    = 0;
    int        done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired, required event never seen", name);
    endtask

    // Reference: a dump emits regs[first..last] in order; the checksum is their XOR.
    function automatic word_t xor_range(input int first, input int last);
        word_t x = '0;
        for (int i = first; i <= last; i++) x ^= regs[i];
        return x;
    endfunction

    task automatic issue_dump(input int first, input int last);
        exp_word_t w;
        for (int i = first; i <= last; i++) begin
            w.index = i;
            w.data  = regs[i];
            exp_q.push_back(w);
        end
        chk_q.push_back(xor_range(first, last));
    endtask

    // Monitor / scoreboard.
    logic  hold_pending = 1'b0;
    idx_t  hold_index;
    word_t hold_data;

    always @(negedge clk) begin
        exp_word_t w;
        word_t     c;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_index", {27'd0, bus.out_index}, {27'd0, hold_index});
                check("hold_data", bus.out_data, hold_data);
            end
            hold_pending = bus.out_valid && !bus.out_ready && !abort;
            hold_index   = bus.out_index;
            hold_data    = bus.out_data;

            if (bus.out_valid && bus.out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL word_unexpected: got index %0d data 0x%08h, required no word",
                             bus.out_index, bus.out_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word_index", {27'd0, bus.out_index}, w.index);
                    check("word_data", bus.out_data, w.data);
                end
            end

            if (done) begin
                done_cnt++;
                check("valid_with_done", {31'd0, bus.out_valid}, 32'd0);
                if (chk_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done, required none");
                end else begin
                    c = chk_q.pop_front();
                    check("done_checksum", checksum, c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(input int ix, input string name);
        int n = 0;
        while (!(bus.out_valid && bus.out_index == idx_t'(ix)) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) fail_now(name);
    endtask

    task automatic wait_done(input int bound, input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            tick();
            cyc++;
        end
        if (!done) fail_now(name);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int    cyc;
        int    d0;
        int    words2;
        word_t c0;

        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        start2        = 1'b0;
        abort2        = 1'b0;
        bus.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = word_t'(i * 3);

        // Reset values, checked before any clock edge.
        #2;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rf_addr", {27'd0, bus.rf_addr}, 32'd0);
        check("rst_rf_addr2", {27'd0, bus2.rf_addr}, 32'd2);
        check("rst_checksum", checksum, 32'd0);
        check("rst_out_index", {27'd0, bus.out_index}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Full dump of i*3 with the consumer always ready: 2 cycles per word.
        issue_dump(0, 31);
        pulse_start();
        wait_done(200, "full_dump_done", cyc);
        check("full_dump_latency", cyc, 32'd64);
        check("full_dump_checksum", checksum, xor_range(0, 31));
        tick();
        check("full_dump_idle", {31'd0, busy}, 32'd0);
        check("full_dump_words_left", exp_q.size(), 32'd0);

        // Back-pressure at index 4 for five cycles.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        issue_dump(0, 31);
        pulse_start();
        wait_word(4, "stall_reach_idx4");
        bus.out_ready = 1'b0;
        c0 = checksum;
        repeat (5) tick();
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_index", {27'd0, bus.out_index}, 32'd4);
        check("stall_data", bus.out_data, regs[4]);
        check("stall_checksum", checksum, c0);
        bus.out_ready = 1'b1;
        wait_done(300, "stall_done", cyc);
        tick();
        check("stall_words_left", exp_q.size(), 32'd0);

        // Abort at index 10 while a handshake is offered.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        issue_dump(0, 31);
        pulse_start();
        wait_word(10, "abort_reach_idx10");
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_checksum", checksum, xor_range(0, 9));
        exp_q.delete();
        chk_q.delete();
        repeat (4) tick();
        check("abort_no_done", done_cnt, d0);

        // start+abort together in IDLE, then random ready and stray start pulses.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        issue_dump(0, 31);
        d0 = done_cnt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 2000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            start         = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
        end
        start         = 1'b0;
        bus.out_ready = 1'b1;
        if (!done) fail_now("random_done");
        repeat (4) tick();
        check("random_one_done", done_cnt, d0 + 1);
        check("random_words_left", exp_q.size(), 32'd0);
        check("random_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of SEND, then a fresh dump.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        issue_dump(0, 31);
        pulse_start();
        wait_word(7, "reset_reach_idx7");
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_rf_addr", {27'd0, bus.rf_addr}, 32'd0);
        check("arst_checksum", checksum, 32'd0);
        check("arst_out_index", {27'd0, bus.out_index}, 32'd0);
        exp_q.delete();
        chk_q.delete();
        tick();
        reset = 1'b0;
        issue_dump(0, 31);
        pulse_start();
        wait_done(200, "post_reset_done", cyc);
        check("post_reset_latency", cyc, 32'd64);
        tick();
        check("post_reset_words_left", exp_q.size(), 32'd0);

        // Single-register dump: FIRST_REG = LAST_REG = 2.
        regs[2] = 32'h0000_2ffc;
        start2  = 1'b1;
        tick();
        start2  = 1'b0;
        words2  = 0;
        cyc     = 0;
        while (!done2 && cyc < 50) begin
            if (bus2.out_valid) begin
                words2++;
                check("single_index", {27'd0, bus2.out_index}, 32'd2);
                check("single_data", bus2.out_data, 32'h0000_2ffc);
            end
            tick();
            cyc++;
        end
        if (!done2) fail_now("single_done");
        check("single_word_count", words2, 32'd1);
        check("single_checksum", checksum2, 32'h0000_2ffc);
        tick();
        check("single_idle", {31'd0, busy2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
